// File: rtl/array_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : array_burst_reader_if
// Brief    : Command, array read port and output stream bundle for the
//            array burst reader.
// Revision : 1.0 - initial release
// ============================================================================
interface array_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic              start;
    logic [ADDR-1:0]   base_addr;
    logic [ADDR:0]     length;
    logic              busy;
    logic              done;
    logic [ADDR-1:0]   mem_read_addr;
    logic [WIDTH-1:0]  mem_read_data;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Reader side: drives the array address and the output stream.
    modport master (
        input  start, base_addr, length, mem_read_data, out_ready,
        output busy, done, mem_read_addr, out_data, out_valid, out_last
    );

    // Environment side: command source, memory array and stream consumer.
    modport slave (
        output start, base_addr, length, mem_read_data, out_ready,
        input  busy, done, mem_read_addr, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/array_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : array_burst_reader
// Brief    : Streams a burst of consecutive words out of a registered-read
//            array, absorbing its one-cycle latency through a two-entry
//            output buffer with valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module array_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    array_burst_reader_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR-1:0]    r_addr;
    logic [ADDR:0]      r_remaining;
    logic               r_inflight;
    logic               r_inflight_last;
    logic               r_done;

    logic [WIDTH-1:0]   r_buf_data [2];
    logic [1:0]         r_buf_last;
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;

    logic               w_accept;
    logic               w_issue;
    logic               w_last_issue;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_room;
    logic [ADDR-1:0]    w_addr_inc;

    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_push       = r_inflight;
    assign w_pop        = (r_count != 2'd0) && bus.out_ready;
    // Occupancy the buffer will need once the in-flight word lands; never
    // negative because a pop requires at least one stored word.
    assign w_room       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_last_issue = w_issue && (r_remaining == {{ADDR{1'b0}}, 1'b1});
    // Explicit wrap so non-power-of-two depths also roll over correctly.
    assign w_addr_inc   = (r_addr == ADDR'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.length == '0) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (w_room < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_remaining == {{ADDR{1'b0}}, 1'b1}) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave only when the last word is popped this edge (or the
                // buffer is already empty) and nothing is still arriving.
                if (!r_inflight && (r_count == {1'b0, w_pop})) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address pointer and remaining-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr      <= bus.base_addr;
            r_remaining <= bus.length;
        end else if (w_issue) begin
            r_addr      <= w_addr_inc;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    // In-flight tracking for the array's one-cycle read latency, and the
    // completion pulse on the DRAIN -> IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            r_done          <= (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
        end
    end

    // Two-entry output FIFO; push and pop may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= bus.mem_read_data;
                r_buf_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == 2'd2)));

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
    assign bus.mem_read_addr = r_addr;
    assign bus.out_data      = r_buf_data[r_rd_ptr];
    assign bus.out_valid     = (r_count != 2'd0);
    assign bus.out_last      = r_buf_last[r_rd_ptr] && (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_array_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_burst_reader
// Brief    : Directed self-checking bench for array_burst_reader with a
//            registered-read memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_burst_reader;

    logic clk;
    logic rst;

    array_burst_reader_if #(.WIDTH(8), .ADDR(4)) ifc ();

    array_burst_reader #(.WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Memory model: registered read, write-before-read returns old data.
    logic [7:0] mem [16];
    logic [7:0] r_rdata;
    logic       preload;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 16);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
        r_rdata <= mem[ifc.mem_read_addr];
    end
    assign ifc.mem_read_data = r_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Collected stream results.
    logic [7:0]  got_d [$];
    logic        got_l [$];
    int          first_cyc;
    int          done_cyc;
    int          hold_changes;
    int          valid_seen;
    logic [31:0] ready_pat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue_start(input logic [3:0] b, input logic [4:0] l);
        ifc.start     = 1'b1;
        ifc.base_addr = b;
        ifc.length    = l;
        tick();
        ifc.start     = 1'b0;
    endtask

    // Record handshakes until done (or a 200-cycle budget); no checking.
    task automatic collect(input int start_cyc);
        int         cyc;
        logic       stall;
        logic [7:0] pd;
        got_d.delete();
        got_l.delete();
        first_cyc    = -1;
        done_cyc     = -1;
        hold_changes = 0;
        valid_seen   = 0;
        stall        = 1'b0;
        pd           = 8'h00;
        cyc          = start_cyc;
        while (done_cyc < 0 && cyc < 200) begin
            ifc.out_ready = ready_pat[cyc % 32];
            if (stall && (!ifc.out_valid || ifc.out_data !== pd)) hold_changes++;
            if (ifc.out_valid) valid_seen++;
            if (ifc.out_valid && ifc.out_ready) begin
                got_d.push_back(ifc.out_data);
                got_l.push_back(ifc.out_last);
                if (first_cyc < 0) first_cyc = cyc;
            end
            stall = ifc.out_valid && !ifc.out_ready;
            pd    = ifc.out_data;
            if (ifc.done) begin
                done_cyc = cyc;
            end else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        ifc.start = 1'b0; ifc.base_addr = '0; ifc.length = '0; ifc.out_ready = 1'b1;
        ready_pat = '1;
        #1;
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
        tests++; if (ifc.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", ifc.out_valid); end
        tests++; if (ifc.out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", ifc.out_last); end
        tests++; if (ifc.out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", ifc.out_data); end
        tests++; if (ifc.mem_read_addr !== 4'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", ifc.mem_read_addr); end
        repeat (3) tick();
        rst = 1'b0; preload = 1'b0;
        tick();
        tests++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin fails++; $display("FAIL reset_release: got busy=%b done=%b expected 0 0", ifc.busy, ifc.done); end
    endtask

    task automatic test_stream();
        logic [7:0] exp [4] = '{8'h12, 8'h13, 8'h14, 8'h15};
        ready_pat = '1;
        issue_start(4'd2, 5'd4);
        tests++; if (ifc.busy !== 1'b1) begin fails++; $display("FAIL stream_busy_c1: got %b expected 1", ifc.busy); end
        tests++; if (ifc.mem_read_addr !== 4'd2) begin fails++; $display("FAIL stream_addr_c1: got %0d expected 2", ifc.mem_read_addr); end
        collect(1);
        tests++; if (got_d.size() != 4) begin fails++; $display("FAIL stream_count: got %0d expected 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                fails++;
                $display("FAIL stream_word[%0d]: got %h last=%b expected %h last=%b", i,
                         (i < got_d.size()) ? got_d[i] : 8'hxx, (i < got_l.size()) ? got_l[i] : 1'bx, exp[i], (i == 3));
            end
        end
        tests++; if (first_cyc != 3) begin fails++; $display("FAIL stream_first_cycle: got %0d expected 3", first_cyc); end
        tests++; if (done_cyc != 7) begin fails++; $display("FAIL stream_done_cycle: got %0d expected 7", done_cyc); end
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL stream_busy_at_done: got %b expected 0", ifc.busy); end
        tick();
        tests++; if (ifc.done !== 1'b0) begin fails++; $display("FAIL stream_done_pulse: got %b expected 0", ifc.done); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4] = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        ready_pat = '1;
        issue_start(4'd14, 5'd4);
        collect(1);
        tests++; if (got_d.size() != 4) begin fails++; $display("FAIL wrap_count: got %0d expected 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                fails++;
                $display("FAIL wrap_word[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, exp[i]);
            end
        end
        tests++; if (done_cyc != 7) begin fails++; $display("FAIL wrap_done_cycle: got %0d expected 7", done_cyc); end
    endtask

    task automatic test_backpressure();
        // bit n = out_ready in cycle n after the start
        ready_pat = 32'b1011_0110_1101_0010_1101_0100_1010_1001;
        issue_start(4'd0, 5'd8);
        collect(1);
        tests++; if (got_d.size() != 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= got_d.size() || got_d[i] !== 8'(8'h10 + i) || got_l[i] !== (i == 7)) begin
                fails++;
                $display("FAIL bp_word[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'h10 + i));
            end
        end
        tests++; if (hold_changes != 0) begin fails++; $display("FAIL bp_hold_stable: got %0d changes expected 0", hold_changes); end
        tests++; if (done_cyc < 0) begin fails++; $display("FAIL bp_done: got timeout expected done"); end
        ifc.out_ready = 1'b1;
    endtask

    task automatic test_len0();
        ready_pat = '1;
        issue_start(4'd3, 5'd0);
        tests++; if (ifc.busy !== 1'b1) begin fails++; $display("FAIL len0_busy_c1: got %b expected 1", ifc.busy); end
        collect(1);
        tests++; if (done_cyc != 2) begin fails++; $display("FAIL len0_done_cycle: got %0d expected 2", done_cyc); end
        tests++; if (valid_seen != 0) begin fails++; $display("FAIL len0_no_valid: got %0d valid cycles expected 0", valid_seen); end
    endtask

    task automatic test_start_while_busy();
        ready_pat = '1;
        issue_start(4'd2, 5'd4);
        // hold a conflicting command for the whole burst
        ifc.start = 1'b1; ifc.base_addr = 4'd9; ifc.length = 5'd2;
        collect(1);
        ifc.start = 1'b0;
        tests++; if (got_d.size() != 4) begin fails++; $display("FAIL busy_start_count: got %0d expected 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got_d.size() || got_d[i] !== 8'(8'h12 + i)) begin
                fails++;
                $display("FAIL busy_start_word[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'h12 + i));
            end
        end
        tests++; if (done_cyc != 7) begin fails++; $display("FAIL busy_start_done_cycle: got %0d expected 7", done_cyc); end
    endtask

    task automatic test_reset_mid_burst();
        ready_pat = '0;
        ifc.out_ready = 1'b0;
        issue_start(4'd2, 5'd4);
        ifc.out_ready = 1'b0;
        repeat (3) tick();
        tests++; if (ifc.out_valid !== 1'b1 || ifc.busy !== 1'b1) begin fails++; $display("FAIL mid_pre_state: got valid=%b busy=%b expected 1 1", ifc.out_valid, ifc.busy); end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({ifc.busy, ifc.done, ifc.out_valid, ifc.out_last} !== 4'b0000 ||
            ifc.out_data !== 8'h00 || ifc.mem_read_addr !== 4'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b valid=%b last=%b data=%h addr=%h expected all 0",
                     ifc.busy, ifc.done, ifc.out_valid, ifc.out_last, ifc.out_data, ifc.mem_read_addr);
        end
        tick();
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (2) begin
            tick();
            tests++; if (ifc.done !== 1'b0 || ifc.out_valid !== 1'b0) begin fails++; $display("FAIL mid_no_done: got done=%b valid=%b expected 0 0", ifc.done, ifc.out_valid); end
        end
        test_stream();
    endtask

    task automatic test_concurrent_write();
        logic [7:0] exp [3] = '{8'h14, 8'hAA, 8'h16};
        ready_pat = '1;
        issue_start(4'd5, 5'd1);
        // the reader issues address 5 on this coming edge
        we = 1'b1; waddr = 4'd5; wdata = 8'hAA;
        tick();
        we = 1'b0;
        collect(2);
        tests++; if (got_d.size() != 1 || got_d[0] !== 8'h15) begin fails++; $display("FAIL cw_old_value: got %h expected 15", (got_d.size() > 0) ? got_d[0] : 8'hxx); end
        tests++; if (done_cyc != 4) begin fails++; $display("FAIL cw_done_cycle: got %0d expected 4", done_cyc); end
        issue_start(4'd4, 5'd3);
        collect(1);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= got_d.size() || got_d[i] !== exp[i]) begin
                fails++;
                $display("FAIL cw_new_word[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_len0();
        test_start_while_busy();
        test_reset_mid_burst();
        test_concurrent_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/array_burst_reader.md
# array_burst_reader

Read-side client for the team's registered-read memory array. On a start command it streams `length` consecutive words beginning at `base_addr` out of the array, absorbing the array's one-cycle read latency and applying valid/ready backpressure. A two-entry output buffer sustains one word per cycle. It sits between the array's read port and any downstream stream consumer, such as a DMA, a serializer or a checksum unit.

## Interface
- `WIDTH`, 8, data word width; must match the array.
- `DEPTH`, 16, number of array words.
- `ADDR`, `$clog2(DEPTH)`, address width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only while idle.
- `base_addr`  in  ADDR  first word address, captured with `start`.
- `length`  in  ADDR+1  number of words to read, captured with `start`; 0 is legal.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `mem_read_addr`  out  ADDR  registered address to the array read port.
- `mem_read_data`  in  WIDTH  array registered read data.
- `out_data`  out  WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `out_last`  out  1  high with the final word of a burst.

## Operation
- **Array contract:** `mem_read_data` during cycle t+1 equals the word at the address `mem_read_addr` carried at edge t.
  - The array samples the address every edge; there is no read enable.
  - If the array is written to the same address at edge t, the reader sees the old word. This is legal and not corrected.
- **FSM states:** IDLE, READ, DRAIN.
  - IDLE -> READ: `start`=1 at an edge. Captures `base_addr` into the address register and `length` into the remaining counter.
  - IDLE -> DRAIN: `start`=1 with `length`=0 goes directly to DRAIN with nothing to read.
  - READ -> DRAIN: on the edge that issues the last address.
  - DRAIN -> IDLE: once no read is in flight and the buffer is empty. `done`=1 for exactly the first IDLE cycle.
  - `start` outside IDLE is ignored.
- **Issue rule.** Issue condition: `count + inflight - pop < 2`, where:
  - `count` is buffer occupancy (0..2);
  - `inflight` is 1 if an issue occurred at the previous edge;
  - `pop` is `out_valid & out_ready`.
- **On an issue edge:**
  - `inflight` sets for the next cycle.
  - The address register increments, wrapping from DEPTH-1 to 0 (also correct for non-power-of-two DEPTH).
  - The remaining counter decrements.
- **Capture:** while `inflight`=1, `mem_read_data` is written into the buffer at the edge. The last word of a burst is tagged with the last flag.
- **Buffer:** 2-entry FIFO.
  - `out_data`, `out_valid` and `out_last` come from the head entry.
  - Data is held stable while `out_valid`=1 and `out_ready`=0.
  - Push and pop in the same edge are allowed.
  - It never overflows; the issue rule guarantees this.
- **Lengths above DEPTH** re-read from the wrapped address. They are not clamped.
- **Reset** (any time, including mid-burst):
  - The FSM goes to IDLE, the buffer is flushed and any in-flight word is discarded. No `done` is produced.
  - Output values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_read_addr`=0.

## Timing
- `start` accepted at edge 0 -> `busy`=1 and `mem_read_addr`=`base_addr` in cycle 1.
  - First issue at edge 1, capture at edge 2.
  - `out_valid`=1 with word `base_addr` in cycle 3, so first-word latency is 3 cycles.
- With `out_ready` held at 1, throughput is one word per cycle. A burst of N words occupies cycles 3..N+2.
- Final handshake at edge K -> cycle K+1: `done`=1, `busy`=0.
  - A new `start` is accepted at edge K+1.
- `length`=0 accepted at edge 0 -> `done`=1 in cycle 2. No `out_valid` is produced.
- Backpressure:
  - Deasserting `out_ready` stops issue within one cycle.
  - Reasserting it resumes one word per cycle with no bubble once the buffer holds 2 words.

## Test plan
- **Preload and stream:** preload mem[i]=i+0x10, start base=2 len=4, ready=1 -> words 0x12,0x13,0x14,0x15 in cycles 3-6; `out_last` only on 0x15; `done` in cycle 7.
- **Wrap-around:** base=14 len=4, DEPTH=16 -> addresses 14,15,0,1 in order, data matches.
- **Backpressure:** ready toggled 1,0,0,1,0,1... during len=8 -> all 8 words delivered exactly once, in order, data stable while stalled; no overflow assertion fires.
- **Edge commands:** len=0 -> `done` in cycle 2, no `out_valid`; `start` pulsed while busy -> ignored, burst unchanged.
- **Reset mid-burst:** assert `rst` while busy with 2 buffered words -> all outputs at reset values immediately; a new start afterwards behaves as in the preload-and-stream scenario.
- **Concurrent write:** write mem[5]=0xAA on the edge the reader issues address 5 -> old value streamed; a second burst over address 5 returns 0xAA.
